// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising memory controller: FSM state
// encoding, access-size decode and the default IO region selector.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIfRd,
    StLsRd,
    StLsWr,
    StDone
  } state_e;

  // addr[17:16] value that selects the IO region
  localparam logic [1:0] IoHiDefault = 2'b11;

  // funct3[1:0] -> number of bytes in the access (1, 2 or 4)
  function automatic logic [2:0] size_bytes(input logic [1:0] f);
    logic [2:0] n;
    unique case (f)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serves MEM-stage loads/stores and IF fetches one at a
// time, serialising each access onto the byte-wide RAM/IO bus.
// Optional feature: define MEMCTRL_IO_BACKPRESSURE_EN to add io_buffer_full_i,
// which holds IO-region write bytes while the IO buffer is full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = IoHiDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy_in,
  input  logic              wr_enable_i,
  input  logic              wr_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_data_i,
  output logic              is_mem_output_o,
  output logic              load_store_ready_o,
  output logic [31:0]       load_data_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [31:0]       inst_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
`ifdef MEMCTRL_IO_BACKPRESSURE_EN
  input  logic              io_buffer_full_i,
`endif
  output logic              ram_wr_o
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              is_if_q, is_if_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       inst_q, inst_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic              ls_ready;
  logic              if_ready;
  logic              wr_stall;
  logic [1:0]        byte_idx;

  // Only the size bits of funct3 matter; the sign-extension bit is ignored
  logic unused_funct3;
  assign unused_funct3 = funct3_i[2];

  assign cur_addr = base_q + ADDR_W'(cnt_q);
  // cnt=k captures the byte addressed at k-1
  assign byte_idx = 2'(cnt_q - 3'd1);

`ifdef MEMCTRL_IO_BACKPRESSURE_EN
  assign wr_stall = (cur_addr[17:16] == IO_HI) && io_buffer_full_i;
`else
  assign wr_stall = 1'b0;
`endif

  // Next-state, byte assembly and bus drive
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    is_if_d     = is_if_q;
    load_data_d = load_data_q;
    inst_d      = inst_q;
    ram_a       = '0;
    ram_dout    = 8'h00;
    ram_wr      = 1'b0;
    ls_ready    = 1'b0;
    if_ready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Data port has priority; IF is only taken when MEM is quiet
        if (wr_enable_i) begin
          base_d  = ls_addr_i;
          n_d     = size_bytes(funct3_i[1:0]);
          wdata_d = ls_data_i;
          rbuf_d  = '0;
          is_if_d = 1'b0;
          cnt_d   = 3'd0;
          state_d = wr_i ? StLsWr : StLsRd;
        end else if (if_req_i) begin
          base_d  = if_addr_i;
          n_d     = 3'd4;
          rbuf_d  = '0;
          is_if_d = 1'b1;
          cnt_d   = 3'd0;
          state_d = StIfRd;
        end
      end

      StIfRd, StLsRd: begin
        if (cnt_q < n_q) begin
          ram_a = cur_addr;
        end
        if (cnt_q != 3'd0) begin
          rbuf_d[{byte_idx, 3'b000} +: 8] = ram_din_i;
        end
        if (cnt_q == n_q) begin
          state_d = StDone;
          if (is_if_q) begin
            inst_d = rbuf_d;
          end else begin
            load_data_d = rbuf_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      StLsWr: begin
        ram_a = cur_addr;
        if (!wr_stall) begin
          ram_wr   = 1'b1;
          ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          if (cnt_q == n_q - 3'd1) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      StDone: begin
        ls_ready = !is_if_q;
        if_ready = is_if_q;
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Global pause: nothing may commit to the bus or complete
    if (!rdy_in) begin
      ram_wr   = 1'b0;
      ram_dout = 8'h00;
      ls_ready = 1'b0;
      if_ready = 1'b0;
    end
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      is_if_q     <= 1'b0;
      load_data_q <= '0;
      inst_q      <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      is_if_q     <= is_if_d;
      load_data_q <= load_data_d;
      inst_q      <= inst_d;
    end
  end

  assign is_mem_output_o    = wr_enable_i;
  assign load_store_ready_o = ls_ready;
  assign if_ready_o         = if_ready;
  assign load_data_o        = load_data_q;
  assign inst_o             = inst_q;
  assign ram_a_o            = ram_a;
  assign ram_dout_o         = ram_dout;
  assign ram_wr_o           = ram_wr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy_in = 1'b1;
  logic        wr_enable = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_data = '0;
  logic        is_mem_output;
  logic        ls_ready;
  logic [31:0] load_data;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] inst;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_full = 1'b0;

  logic [7:0]  rmem [0:4095];
  logic [7:0]  wmem [0:4095];
  int          wr_count = 0;
  int          wr_before;
  int          checks = 0;
  int          errors = 0;

  mem_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy_in            (rdy_in),
    .wr_enable_i       (wr_enable),
    .wr_i              (wr),
    .funct3_i          (funct3),
    .ls_addr_i         (ls_addr),
    .ls_data_i         (ls_data),
    .is_mem_output_o   (is_mem_output),
    .load_store_ready_o(ls_ready),
    .load_data_o       (load_data),
    .if_req_i          (if_req),
    .if_addr_i         (if_addr),
    .if_ready_o        (if_ready),
    .inst_o            (inst),
    .ram_din_i         (ram_din),
    .ram_dout_o        (ram_dout),
    .ram_a_o           (ram_a),
`ifdef MEMCTRL_IO_BACKPRESSURE_EN
    .io_buffer_full_i  (io_full),
`endif
    .ram_wr_o          (ram_wr)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, held by the global pause
  always @(posedge clk) begin
    if (rdy_in) ram_din <= rmem[ram_a[11:0]];
    if (ram_wr === 1'b1) begin
      wmem[ram_a[11:0]] <= ram_dout;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rmem[i] = 8'h00;

    // Reset state
    tick;
    tick;
    check("rst_ls_ready", ls_ready, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_load_data", load_data, 0);
    check("rst_inst", inst, 0);
    rst_n = 1'b1;
    tick;

    // LW 0x100
    rmem[12'h100] = 8'h11; rmem[12'h101] = 8'h22;
    rmem[12'h102] = 8'h33; rmem[12'h103] = 8'h44;
    wr_enable = 1'b1; wr = 1'b0; funct3 = 3'b010; ls_addr = 32'h100;
    #1;
    check("lw_is_mem_output", is_mem_output, 1);
    for (int i = 1; i <= 6; i++) begin
      tick;
      check("lw_ready", ls_ready, 32'(i == 6));
      if (i <= 4) check("lw_addr", ram_a, 32'h100 + i - 1);
    end
    check("lw_data", load_data, 32'h44332211);
    wr_enable = 1'b0;
    tick;
    check("lw_ready_drop", ls_ready, 0);

    // SB 0x200
    wr_enable = 1'b1; wr = 1'b1; funct3 = 3'b000; ls_addr = 32'h200; ls_data = 32'hDEADBEEF;
    tick;
    check("sb_wr", ram_wr, 1);
    check("sb_addr", ram_a, 32'h200);
    check("sb_dout", ram_dout, 32'hEF);
    check("sb_ready_early", ls_ready, 0);
    tick;
    check("sb_ready", ls_ready, 1);
    check("sb_wr_done", ram_wr, 0);
    check("sb_load_kept", load_data, 32'h44332211);
    wr_enable = 1'b0;
    tick;
    check("sb_mem", wmem[12'h200], 32'hEF);

    // SH wrapping past 0xFFFFFFFF
    wr_enable = 1'b1; wr = 1'b1; funct3 = 3'b001; ls_addr = 32'hFFFFFFFF; ls_data = 32'h00001234;
    tick;
    check("sh_addr0", ram_a, 32'hFFFFFFFF);
    check("sh_dout0", ram_dout, 32'h34);
    tick;
    check("sh_addr1", ram_a, 32'h00000000);
    check("sh_dout1", ram_dout, 32'h12);
    tick;
    check("sh_ready", ls_ready, 1);
    wr_enable = 1'b0;
    tick;

    // LH and IF requested together: data first, then fetch
    rmem[12'h300] = 8'hA1; rmem[12'h301] = 8'hB2;
    rmem[12'h400] = 8'h01; rmem[12'h401] = 8'h02;
    rmem[12'h402] = 8'h03; rmem[12'h403] = 8'h04;
    wr_enable = 1'b1; wr = 1'b0; funct3 = 3'b001; ls_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 1; i <= 4; i++) begin
      tick;
      check("lh_ready", ls_ready, 32'(i == 4));
      check("lh_if_quiet", if_ready, 0);
    end
    check("lh_data", load_data, 32'h0000B2A1);
    wr_enable = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check("if_ready", if_ready, 32'(i == 7));
      check("if_ls_quiet", ls_ready, 0);
      if (i >= 2 && i <= 5) check("if_addr", ram_a, 32'h400 + i - 2);
    end
    check("if_inst", inst, 32'h04030201);
    if_req = 1'b0;
    tick;
    check("if_ready_drop", if_ready, 0);

    // LW with rdy_in low for 3 cycles mid-access
    rmem[12'h500] = 8'h55; rmem[12'h501] = 8'h66;
    rmem[12'h502] = 8'h77; rmem[12'h503] = 8'h88;
    wr_enable = 1'b1; wr = 1'b0; funct3 = 3'b010; ls_addr = 32'h500;
    for (int i = 1; i <= 9; i++) begin
      tick;
      check("pause_ready", ls_ready, 32'(i == 9));
      if (i == 2) rdy_in = 1'b0;
      if (i == 5) rdy_in = 1'b1;
    end
    check("pause_data", load_data, 32'h88776655);
    wr_enable = 1'b0;
    tick;

    // Pause during a store suppresses the write strobe
    wr_enable = 1'b1; wr = 1'b1; funct3 = 3'b001; ls_addr = 32'h700; ls_data = 32'h0000BEEF;
    tick;
    rdy_in = 1'b0;
    #1;
    check("wpause_wr0", ram_wr, 0);
    tick;
    check("wpause_wr1", ram_wr, 0);
    rdy_in = 1'b1;
    #1;
    check("wpause_resume_wr", ram_wr, 1);
    check("wpause_resume_a", ram_a, 32'h700);
    check("wpause_resume_dout", ram_dout, 32'hEF);
    tick;
    check("wpause_a1", ram_a, 32'h701);
    check("wpause_dout1", ram_dout, 32'hBE);
    tick;
    check("wpause_ready", ls_ready, 1);
    wr_enable = 1'b0;
    tick;

    // Reset in the middle of a SW
    wr_before = wr_count;
    wr_enable = 1'b1; wr = 1'b1; funct3 = 3'b010; ls_addr = 32'h600; ls_data = 32'hCAFEF00D;
    tick;
    tick;
    check("rsw_wr_mid", ram_wr, 1);
    rst_n = 1'b0;
    tick;
    check("rsw_wr", ram_wr, 0);
    check("rsw_ready", ls_ready, 0);
    check("rsw_load", load_data, 0);
    wr_enable = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rsw_no_ready", ls_ready, 0);
    end
    check("rsw_wr_count", wr_count - wr_before, 2);
    check("rsw_byte1", wmem[12'h601], 32'hF0);

`ifdef MEMCTRL_IO_BACKPRESSURE_EN
    // SB into IO region while the IO buffer is full
    io_full = 1'b1;
    wr_enable = 1'b1; wr = 1'b1; funct3 = 3'b000; ls_addr = 32'h30000; ls_data = 32'h0000005A;
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("bp_hold_wr", ram_wr, 0);
      check("bp_hold_ready", ls_ready, 0);
    end
    io_full = 1'b0;
    #1;
    check("bp_wr", ram_wr, 1);
    check("bp_addr", ram_a, 32'h30000);
    check("bp_dout", ram_dout, 32'h5A);
    tick;
    check("bp_ready", ls_ready, 1);
    wr_enable = 1'b0;
    tick;
    check("bp_mem", wmem[12'h000], 32'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
